// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one uart_tx among
// four byte producers; all outputs come straight from registers.
module uart_tx_arbiter #(
  parameter int unsigned BUSY_TIMEOUT = 131072
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [3:0]  last,
  input  logic [31:0] data_in,
  output logic [3:0]  ack,
  output logic [3:0]  grant,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_ready,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned CW = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    own_q, own_d;
  logic          lock_q, lock_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    ack_q, ack_d;
  logic [3:0]    grant_q, grant_d;
  logic [7:0]    data_q, data_d;
  logic          send_q, send_d;
  logic          terr_q, terr_d;

  logic [1:0]    pick;
  logic [1:0]    cand;
  logic [1:0]    sel;
  logic          found;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      own_q   <= 2'd0;
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      send_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      lock_q  <= lock_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      send_q  <= send_d;
      terr_q  <= terr_d;
    end
  end

  // First requester after ptr, wrapping around to ptr itself last.
  always_comb begin
    pick  = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    lock_d  = lock_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    grant_d = grant_q;
    data_d  = data_q;
    send_d  = send_q;
    terr_d  = terr_q;
    sel     = own_q;
    unique case (state_q)
      IDLE: begin
        if (tx_ready && (|req)) begin
          if (lock_q && req[own_q]) begin
            sel = own_q;
          end else begin
            sel    = pick;
            lock_d = 1'b0;
          end
          own_d   = sel;
          data_d  = data_in[{sel, 3'b000} +: 8];
          ack_d   = 4'(1) << sel;
          grant_d = 4'(1) << sel;
          last_d  = last[sel];
          cnt_d   = '0;
          send_d  = 1'b1;
          state_d = SEND;
        end else if (!lock_q) begin
          grant_d = '0;
        end
      end
      SEND: begin
        if (!tx_ready) begin
          send_d  = 1'b0;
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          send_d  = 1'b0;
          lock_d  = 1'b0;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          state_d = IDLE;
          if (last_q) begin
            lock_d  = 1'b0;
            ptr_d   = own_q;
            grant_d = '0;
          end else begin
            lock_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack         = ack_q;
    grant       = grant_q;
    tx_data     = data_q;
    tx_send     = send_q;
    busy        = (state_q != IDLE);
    timeout_err = terr_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: arbitration order, packet lock,
// lock drop, send timeout and mid-frame reset.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [31:0] data_in;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_ready;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.BUSY_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .last       (last),
    .data_in    (data_in),
    .ack        (ack),
    .grant      (grant),
    .tx_data    (tx_data),
    .tx_send    (tx_send),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete frame from selection through tx_ready returning high.
  task automatic frame(input string tag, input logic [3:0] g,
                       input logic [7:0] d, input logic [3:0] g_after);
    tick();
    chk({tag, ".ack"}, 32'(ack), 32'(g));
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".data"}, 32'(tx_data), 32'(d));
    chk({tag, ".send"}, 32'(tx_send), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, ".ack_drop"}, 32'(ack), 32'd0);
    chk({tag, ".send_hold"}, 32'(tx_send), 32'd1);
    tx_ready = 1'b0;
    tick();
    chk({tag, ".send_fall"}, 32'(tx_send), 32'd0);
    chk({tag, ".busy_wait"}, 32'(busy), 32'd1);
    tick();
    chk({tag, ".busy_wait2"}, 32'(busy), 32'd1);
    tx_ready = 1'b1;
    tick();
    chk({tag, ".busy_done"}, 32'(busy), 32'd0);
    chk({tag, ".grant_after"}, 32'(grant), 32'(g_after));
  endtask

  initial begin
    rst      = 1'b1;
    req      = 4'b0000;
    last     = 4'b0000;
    data_in  = 32'h0;
    tx_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst.ack", 32'(ack), 32'd0);
    chk("rst.grant", 32'(grant), 32'd0);
    chk("rst.data", 32'(tx_data), 32'd0);
    chk("rst.send", 32'(tx_send), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.terr", 32'(timeout_err), 32'd0);

    // uart busy from elsewhere: no selection
    tx_ready = 1'b0;
    req      = 4'b0001;
    last     = 4'b0001;
    data_in  = 32'h0000_00A5;
    tick();
    chk("nordy.busy", 32'(busy), 32'd0);
    chk("nordy.ack", 32'(ack), 32'd0);
    tx_ready = 1'b1;
    frame("single", 4'b0001, 8'hA5, 4'b0000);

    req     = 4'b1111;
    last    = 4'b1111;
    data_in = 32'hD4C3_B2A1;
    frame("rr1", 4'b0010, 8'hB2, 4'b0000);
    frame("rr2", 4'b0100, 8'hC3, 4'b0000);
    frame("rr3", 4'b1000, 8'hD4, 4'b0000);
    frame("rr0", 4'b0001, 8'hA1, 4'b0000);
    frame("rr1b", 4'b0010, 8'hB2, 4'b0000);

    req  = 4'b0010;
    last = 4'b0000;
    frame("drop1", 4'b0010, 8'hB2, 4'b0010);
    req  = 4'b1000;
    last = 4'b1000;
    frame("drop3", 4'b1000, 8'hD4, 4'b0000);

    req     = 4'b0101;
    last    = 4'b0000;
    data_in = 32'h00EE_0011;
    frame("lock11", 4'b0001, 8'h11, 4'b0001);
    data_in = 32'h00EE_0022;
    frame("lock22", 4'b0001, 8'h22, 4'b0001);
    data_in = 32'h00EE_0033;
    last    = 4'b0001;
    frame("lock33", 4'b0001, 8'h33, 4'b0000);
    req  = 4'b0100;
    last = 4'b0100;
    frame("lockEE", 4'b0100, 8'hEE, 4'b0000);

    req     = 4'b0001;
    last    = 4'b0001;
    data_in = 32'h0000_005A;
    tick();
    chk("to.ack", 32'(ack), 32'd1);
    chk("to.send0", 32'(tx_send), 32'd1);
    req = 4'b0000;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk($sformatf("to.send%0d", i), 32'(tx_send), 32'd1);
    end
    tick();
    chk("to.send_end", 32'(tx_send), 32'd0);
    chk("to.terr", 32'(timeout_err), 32'd1);
    chk("to.busy", 32'(busy), 32'd0);
    chk("to.grant", 32'(grant), 32'd0);

    // ptr must not have moved: 0 wins over 1
    req     = 4'b0011;
    last    = 4'b0011;
    data_in = 32'h0000_6B5B;
    frame("post_to", 4'b0001, 8'h5B, 4'b0000);
    chk("post_to.terr", 32'(timeout_err), 32'd1);

    req  = 4'b0010;
    last = 4'b0010;
    tick();
    chk("mid.grant", 32'(grant), 32'b0010);
    chk("mid.send", 32'(tx_send), 32'd1);
    rst     = 1'b1;
    req     = 4'b1001;
    last    = 4'b1001;
    data_in = 32'hC300_00C0;
    tick();
    rst = 1'b0;
    chk("mid.ack", 32'(ack), 32'd0);
    chk("mid.grant0", 32'(grant), 32'd0);
    chk("mid.data", 32'(tx_data), 32'd0);
    chk("mid.send0", 32'(tx_send), 32'd0);
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.terr", 32'(timeout_err), 32'd0);
    frame("after_rst", 4'b0001, 8'hC0, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
